div_share_arbiter: RTL and testbench

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

---
 rtl/div_share_arbiter_pkg.sv | 15 +
 rtl/div_share_arbiter_rr_grant.sv | 35 +++
 rtl/div_share_arbiter.sv | 120 ++++++++++++
 tb/tb_div_share_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_arbiter_pkg.sv
// Shared types and default sizing for the divider-sharing arbiter.
package div_share_arbiter_pkg;

    localparam int DEF_BITS    = 16;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_share_arbiter_rr_grant.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_grant #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    index,
    output logic             found
);

    int          sum;
    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N_REQ) sum = sum - N_REQ;
            cand = IW'(sum);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Arbitrates N_REQ requesters onto one external iterative divider, one job at a time.
module div_share_arbiter
    import div_share_arbiter_pkg::*;
#(
    parameter int BITS    = DEF_BITS,
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*BITS-1:0] req_dividendo,
    input  logic [N_REQ*BITS-1:0] req_divisor,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [BITS-1:0]       resp_result,
    output logic                  resp_error,
    output logic [BITS-1:0]       div_dividendo,
    output logic [BITS-1:0]       div_divisor,
    output logic                  div_reset,
    input  logic [BITS-1:0]       div_result,
    input  logic                  div_ready
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] op_dividendo;
    logic [BITS-1:0] op_divisor;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             grant_valid;
    logic [BITS-1:0]  sel_dividendo;
    logic [BITS-1:0]  sel_divisor;

    rr_grant #(.N_REQ(N_REQ)) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (gidx),
        .found (grant_valid)
    );

    assign sel_dividendo = req_dividendo[gidx*BITS +: BITS];
    assign sel_divisor   = req_divisor[gidx*BITS +: BITS];

    // Latched operands feed the divider directly, so they stay put for the whole job.
    assign div_dividendo = op_dividendo;
    assign div_divisor   = op_divisor;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: only non-blocking assignments here, so every register samples pre-edge values.
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            cnt          <= '0;
            op_dividendo <= '0;
            op_divisor   <= '0;
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_result  <= '0;
            resp_error   <= 1'b0;
            div_reset    <= 1'b1;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        req_ready    <= grant;
                        owner        <= gidx;
                        op_dividendo <= sel_dividendo;
                        op_divisor   <= sel_divisor;
                        rr_ptr       <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                        if (sel_divisor == '0) begin
                            resp_result <= '1;
                            resp_error  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_reset <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    div_reset <= 1'b0;
                    cnt       <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    // A result arriving on the timeout cycle still wins.
                    if (div_ready) begin
                        resp_result <= div_result;
                        resp_error  <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        cnt         <= cnt + 1'b1;
                        resp_result <= '0;
                        resp_error  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    resp_valid <= N_REQ'(1) << owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench: behavioural divider model plus hand-computed grant order, results and timing.
module tb_div_share_arbiter;
    import div_share_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_dividendo;
    logic [63:0] req_divisor;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [15:0] resp_result;
    logic        resp_error;
    logic [15:0] div_dividendo;
    logic [15:0] div_divisor;
    logic        div_reset;
    logic [15:0] div_result = '0;
    logic        div_ready  = 1'b0;

    logic [3:0]  t_req_valid;
    logic [3:0]  t_req_ready;
    logic [3:0]  t_resp_valid;
    logic [15:0] t_resp_result;
    logic        t_resp_error;
    logic [15:0] t_div_dividendo;
    logic [15:0] t_div_divisor;
    logic        t_div_reset;
    logic [15:0] zero_word = '0;
    logic        zero_bit  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 20;
    int m_cnt = 0;
    int oh_bad = 0;
    int dr_hi = 0;
    int g_own[$];
    int g_cyc[$];
    int r_own[$];
    int r_cyc[$];
    int r_res[$];
    int r_err[$];
    int t_g_cyc = 0;
    int t_r_cyc = 0;
    int t_r_cnt = 0;
    int t_r_res = 0;
    int t_r_err = 0;

    div_share_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_dividendo (req_dividendo),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_result   (resp_result),
        .resp_error    (resp_error),
        .div_dividendo (div_dividendo),
        .div_divisor   (div_divisor),
        .div_reset     (div_reset),
        .div_result    (div_result),
        .div_ready     (div_ready)
    );

    // Second instance with a short timeout and a divider that never finishes.
    div_share_arbiter #(.TIMEOUT(15)) dut_to (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (t_req_valid),
        .req_dividendo (req_dividendo),
        .req_divisor   (req_divisor),
        .req_ready     (t_req_ready),
        .resp_valid    (t_resp_valid),
        .resp_result   (t_resp_result),
        .resp_error    (t_resp_error),
        .div_dividendo (t_div_dividendo),
        .div_divisor   (t_div_divisor),
        .div_reset     (t_div_reset),
        .div_result    (zero_word),
        .div_ready     (zero_bit)
    );

    always #5 clk = ~clk;

    // Divider model: restarts on div_reset, done flag sticks until the next div_reset.
    always @(posedge clk) begin
        if (div_reset) begin
            m_cnt     <= 0;
            div_ready <= 1'b0;
        end else if (!div_ready) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == lat) begin
                div_ready  <= 1'b1;
                div_result <= (div_divisor != 0) ? div_dividendo / div_divisor : 16'hFFFF;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (req_ready != '0) begin
            g_own.push_back(oh2i(req_ready));
            g_cyc.push_back(cyc);
        end
        if (resp_valid != '0) begin
            r_own.push_back(oh2i(resp_valid));
            r_res.push_back(int'(resp_result));
            r_err.push_back(int'(resp_error));
            r_cyc.push_back(cyc);
        end
        if ($countones(req_ready) > 1 || $countones(resp_valid) > 1) oh_bad++;
        if (div_reset && !reset) dr_hi++;
        if (t_req_ready != '0) t_g_cyc = cyc;
        if (t_resp_valid != '0) begin
            t_r_cnt++;
            t_r_cyc = cyc;
            t_r_res = int'(t_resp_result);
            t_r_err = int'(t_resp_error);
        end
        req_valid   = req_valid & ~req_ready;
        t_req_valid = t_req_valid & ~t_req_ready;
    endtask

    task automatic clear_logs();
        g_own.delete(); g_cyc.delete();
        r_own.delete(); r_cyc.delete(); r_res.delete(); r_err.delete();
        dr_hi = 0;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_dividendo[i*16 +: 16] = 16'(a);
        req_divisor[i*16 +: 16]   = 16'(b);
    endtask

    task automatic wait_grant(input string tag, input int n, input int budget);
        int k = 0;
        while (g_own.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(g_own.size() >= n), 32'd1);
    endtask

    task automatic wait_resp(input string tag, input int n, input int budget);
        int k = 0;
        while (r_own.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(r_own.size() >= n), 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        t_req_valid   = '0;
        req_dividendo = '0;
        req_divisor   = '0;
        repeat (2) tick();
        check("rst_state",     32'(dut.state), 32'(IDLE));
        check("rst_rr_ptr",    32'(dut.rr_ptr), 0);
        check("rst_cnt",       32'(dut.cnt), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_result",    32'(resp_result), 0);
        check("rst_error",     32'(resp_error), 0);
        check("rst_operands",  {div_dividendo, div_divisor}, 0);
        check("rst_div_reset", 32'(div_reset), 1);
        reset = 1'b0;
        tick();

        // Single job, requester 1: 100/7 with 20-cycle divider.
        clear_logs();
        set_op(1, 100, 7);
        req_valid = 4'b0010;
        wait_grant("j1_grant_seen", 1, 10);
        repeat (3) tick();
        check("j1_div_dividendo", 32'(div_dividendo), 100);
        check("j1_div_divisor",   32'(div_divisor), 7);
        check("j1_div_reset_run", 32'(div_reset), 0);
        wait_resp("j1_resp_seen", 1, 60);
        if (r_own.size() > 0 && g_own.size() > 0) begin
            check("j1_grant_owner", 32'(g_own[0]), 1);
            check("j1_ready_pulses", 32'(g_own.size()), 1);
            check("j1_resp_owner", 32'(r_own[0]), 1);
            check("j1_result",     32'(r_res[0]), 14);
            check("j1_error",      32'(r_err[0]), 0);
            check("j1_latency",    32'(r_cyc[0] - g_cyc[0]), 23);
            check("j1_load_cycles", 32'(dr_hi), 1);
        end

        // Divide by zero, requester 2: divider bypassed.
        clear_logs();
        set_op(2, 55, 0);
        req_valid = 4'b0100;
        wait_resp("dz_resp_seen", 1, 20);
        if (r_own.size() > 0 && g_own.size() > 0) begin
            check("dz_owner",   32'(r_own[0]), 2);
            check("dz_result",  32'(r_res[0]), 32'h0000FFFF);
            check("dz_error",   32'(r_err[0]), 1);
            check("dz_latency", 32'(r_cyc[0] - g_cyc[0]), 1);
            check("dz_no_div_reset", 32'(dr_hi), 0);
        end

        // Divider still shows done from job 1 (result 14); fresh result must be used.
        clear_logs();
        lat = 5;
        set_op(0, 9, 3);
        req_valid = 4'b0001;
        wait_resp("st_resp_seen", 1, 40);
        if (r_own.size() > 0 && g_own.size() > 0) begin
            check("st_owner",   32'(r_own[0]), 0);
            check("st_result",  32'(r_res[0]), 3);
            check("st_error",   32'(r_err[0]), 0);
            check("st_latency", 32'(r_cyc[0] - g_cyc[0]), 8);
        end

        // All four requesters at once from reset, two waves.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clear_logs();
        set_op(0, 50, 5);
        set_op(1, 81, 9);
        set_op(2, 1000, 10);
        set_op(3, 7, 8);
        req_valid = 4'b1111;
        wait_resp("rr_wave1_seen", 4, 100);
        if (r_own.size() >= 4 && g_own.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_grant_%0d", i), 32'(g_own[i]), 32'(i));
                check($sformatf("rr_owner_%0d", i), 32'(r_own[i]), 32'(i));
            end
            check("rr_res_0", 32'(r_res[0]), 10);
            check("rr_res_1", 32'(r_res[1]), 9);
            check("rr_res_2", 32'(r_res[2]), 100);
            check("rr_res_3", 32'(r_res[3]), 0);
            check("rr_job_latency", 32'(r_cyc[0] - g_cyc[0]), 8);
            check("rr_next_grant",  32'(g_cyc[1] - r_cyc[0]), 1);
        end
        req_valid = 4'b1111;
        wait_resp("rr_wave2_seen", 8, 100);
        if (r_own.size() >= 8 && g_own.size() >= 8) begin
            check("rr_wave2_first", 32'(g_own[4]), 0);
            check("rr_wave2_last",  32'(g_own[7]), 3);
            check("rr_wave2_res0",  32'(r_res[4]), 10);
        end

        // Reset three cycles into RUN abandons the job silently.
        clear_logs();
        lat = 20;
        set_op(1, 200, 3);
        req_valid = 4'b0010;
        wait_grant("ab_grant_seen", 1, 10);
        repeat (3) tick();
        check("ab_state_run", 32'(dut.state), 32'(RUN));
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (30) tick();
        check("ab_no_resp",     32'(r_own.size()), 0);
        check("ab_state_idle",  32'(dut.state), 32'(IDLE));
        check("ab_rr_ptr",      32'(dut.rr_ptr), 0);
        clear_logs();
        set_op(3, 60, 4);
        req_valid = 4'b1010;
        wait_resp("ab_after_seen", 2, 80);
        if (r_own.size() >= 2) begin
            check("ab_first_owner", 32'(r_own[0]), 1);
            check("ab_first_res",   32'(r_res[0]), 66);
            check("ab_second_owner", 32'(r_own[1]), 3);
            check("ab_second_res",  32'(r_res[1]), 15);
        end

        // Timeout on the TIMEOUT=15 instance.
        set_op(2, 77, 7);
        t_req_valid = 4'b0100;
        for (int k = 0; k < 60 && t_r_cnt == 0; k++) tick();
        check("to_resp_seen", 32'(t_r_cnt), 1);
        check("to_latency",   32'(t_r_cyc - t_g_cyc), 17);
        check("to_result",    32'(t_r_res), 0);
        check("to_error",     32'(t_r_err), 1);

        check("onehot_outputs", 32'(oh_bad), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
